// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared 32-bit ALU: grants one request at a time,
// registers operands, executes for one cycle and returns a tagged response with flags.

module alu32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  alu_control,
  output logic [31:0] alu_out,
  output logic        zout,
  output logic        sout,
  output logic        vout
);
  logic [31:0] sum;
  logic [31:0] diff;

  // NOTE: every always_comb output gets a default first so no path can leave it
  // unassigned; an unassigned path would infer a latch.
  always_comb begin
    sum     = a + b;
    diff    = a - b;
    alu_out = '0;
    vout    = 1'b0;
    unique case (alu_control)
      3'b000: alu_out = a & b;
      3'b001: alu_out = a | b;
      3'b010: begin
        alu_out = sum;
        vout    = (a[31] == b[31]) && (sum[31] != a[31]);
      end
      3'b011: alu_out = a ^ b;
      3'b100: alu_out = ~(a | b);
      3'b110: begin
        alu_out = diff;
        vout    = (a[31] != b[31]) && (diff[31] != a[31]);
      end
      3'b111: alu_out = {31'b0, diff[31]};
      default: alu_out = '0;
    endcase
    zout = (alu_out == '0);
    sout = alu_out[31];
  end
endmodule

module alu_arbiter #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [2:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [2:0]  req1_op,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_data,
  output logic        rsp_z,
  output logic        rsp_v,
  output logic        rsp_s,
  output logic        rsp_err,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_ILL = 3'b101;

  state_e      state_q, state_d;
  logic        prio_q, prio_d;
  logic [31:0] opa_q, opa_d, opb_q, opb_d;
  logic [2:0]  opc_q, opc_d;
  logic        opid_q, opid_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_id_q, rsp_id_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rsp_z_q, rsp_z_d, rsp_v_q, rsp_v_d, rsp_s_q, rsp_s_d, rsp_err_q, rsp_err_d;

  logic        grant;
  logic        idle;
  logic [31:0] alu_out;
  logic        alu_z, alu_s, alu_vout_unused;
  logic        illegal, ovf;

  alu32 u_alu (
    .a           (opa_q),
    .b           (opb_q),
    .alu_control (opc_q),
    .alu_out     (alu_out),
    .zout        (alu_z),
    .sout        (alu_s),
    .vout        (alu_vout_unused)
  );

  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) grant = FIXED_PRIO ? 1'b0 : prio_q;
    else if (req1_valid)          grant = 1'b1;
  end

  // Gated by rst_n so neither requester sees ready while reset is held.
  assign idle       = rst_n && (state_q == IDLE);
  assign req0_ready = idle && !grant && req0_valid;
  assign req1_ready = idle &&  grant && req1_valid;

  // Overflow is derived here from the registered operands rather than the ALU.
  always_comb begin
    illegal = (opc_q == OP_ILL);
    ovf     = 1'b0;
    if (opc_q == OP_ADD) ovf = (opa_q[31] == opb_q[31]) && (alu_out[31] != opa_q[31]);
    if (opc_q == OP_SUB) ovf = (opa_q[31] != opb_q[31]) && (alu_out[31] != opa_q[31]);
  end

  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    opc_d       = opc_q;
    opid_d      = opid_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_z_d     = rsp_z_q;
    rsp_v_d     = rsp_v_q;
    rsp_s_d     = rsp_s_q;
    rsp_err_d   = rsp_err_q;
    unique case (state_q)
      IDLE: begin
        if (req0_ready) begin
          opa_d = req0_a; opb_d = req0_b; opc_d = req0_op; opid_d = 1'b0;
          state_d = EXEC;
        end else if (req1_ready) begin
          opa_d = req1_a; opb_d = req1_b; opc_d = req1_op; opid_d = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        rsp_valid_d = 1'b1;
        rsp_id_d    = opid_q;
        rsp_data_d  = illegal ? '0   : alu_out;
        rsp_z_d     = illegal ? 1'b1 : alu_z;
        rsp_s_d     = illegal ? 1'b0 : alu_s;
        rsp_v_d     = illegal ? 1'b0 : ovf;
        rsp_err_d   = illegal;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          prio_d      = ~rsp_id_q;
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      prio_q      <= 1'b0;
      opa_q       <= '0;
      opb_q       <= '0;
      opc_q       <= '0;
      opid_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
      rsp_z_q     <= 1'b0;
      rsp_v_q     <= 1'b0;
      rsp_s_q     <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      opc_q       <= opc_d;
      opid_q      <= opid_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_z_q     <= rsp_z_d;
      rsp_v_q     <= rsp_v_d;
      rsp_s_q     <= rsp_s_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_z     = rsp_z_q;
  assign rsp_v     = rsp_v_q;
  assign rsp_s     = rsp_s_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: table of single ops, reset mid-response,
// backpressure, and round-robin vs fixed-priority ordering on two instances.

module tb_alu_arbiter;
  logic        clk, rst_n;
  logic        req0_valid, req1_valid, rsp_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_op, req1_op;

  logic        req0_ready, req1_ready, rsp_valid, rsp_id, rsp_z, rsp_v, rsp_s, rsp_err, busy;
  logic [31:0] rsp_data;
  logic        fp_req0_ready, fp_req1_ready, fp_rsp_valid, fp_rsp_id, fp_rsp_z, fp_rsp_v;
  logic        fp_rsp_s, fp_rsp_err, fp_busy;
  logic [31:0] fp_rsp_data;

  int n_cmp = 0;
  int n_mis = 0;

  typedef struct {
    logic        id;
    logic [2:0]  op;
    logic [31:0] a, b, data;
    logic        z, v, s, err;
  } vec_t;

  vec_t vecs[14];

  alu_arbiter #(.FIXED_PRIO(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_z(rsp_z), .rsp_v(rsp_v), .rsp_s(rsp_s), .rsp_err(rsp_err), .busy(busy)
  );

  alu_arbiter #(.FIXED_PRIO(1'b1)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(fp_req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(fp_req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(fp_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(fp_rsp_id), .rsp_data(fp_rsp_data),
    .rsp_z(fp_rsp_z), .rsp_v(fp_rsp_v), .rsp_s(fp_rsp_s), .rsp_err(fp_rsp_err), .busy(fp_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction from one requester with rsp_ready pulsed when the response appears.
  task automatic run_op(input int idx, input vec_t v);
    string t;
    logic  got;
    t = $sformatf("v%0d", idx);
    if (v.id) begin
      req1_a = v.a; req1_b = v.b; req1_op = v.op; req1_valid = 1'b1;
    end else begin
      req0_a = v.a; req0_b = v.b; req0_op = v.op; req0_valid = 1'b1;
    end
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      #1;
      if (v.id ? req1_ready : req0_ready) got = 1'b1;
      else tick();
    end
    check1({t, "_accept"}, got, 1'b1);
    check1({t, "_other_ready"}, v.id ? req0_ready : req1_ready, 1'b0);
    tick();
    // Operands change after acceptance; the in-flight op must not see them.
    if (v.id) begin req1_a = ~v.a; req1_b = 32'h1234_5678; req1_op = 3'b011; end
    else      begin req0_a = ~v.a; req0_b = 32'h1234_5678; req0_op = 3'b011; end
    check1({t, "_exec_ready"}, v.id ? req1_ready : req0_ready, 1'b0);
    check1({t, "_exec_busy"}, busy, 1'b1);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check1({t, "_rsp_valid"}, rsp_valid, 1'b1);
    check1({t, "_rsp_id"}, rsp_id, v.id);
    check({t, "_data"}, rsp_data, v.data);
    check1({t, "_z"}, rsp_z, v.z);
    check1({t, "_v"}, rsp_v, v.v);
    check1({t, "_s"}, rsp_s, v.s);
    check1({t, "_err"}, rsp_err, v.err);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check1({t, "_rsp_done"}, rsp_valid, 1'b0);
  endtask

  logic [31:0] held_data;
  int          bp_bad;
  int          n_rr, n_fp;
  logic        rr_id[4], fp_id[4];
  logic [31:0] rr_dat[4], fp_dat[4];
  int          rr_cyc[4];

  initial begin
    vecs[0]  = '{1'b1, 3'b010, 32'd5,          32'd7,          32'd12,         1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 3'b010, 32'h7FFF_FFFF, 32'd1,          32'h8000_0000, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 3'b110, 32'd5,          32'd5,          32'd0,          1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 3'b111, 32'hFFFF_FFFD, 32'd2,          32'd1,          1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 3'b001, 32'h0000_000F, 32'h0000_00F0, 32'h0000_00FF, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,          1'b1, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 3'b100, 32'd0,          32'd0,          32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 3'b110, 32'h8000_0000, 32'd1,          32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 3'b010, 32'h8000_0000, 32'h8000_0000, 32'd0,          1'b1, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 3'b111, 32'd2,          32'hFFFF_FFFD, 32'd0,          1'b1, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 3'b110, 32'd3,          32'd5,          32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 3'b101, 32'd3,          32'd4,          32'd0,          1'b1, 1'b0, 1'b0, 1'b1};
    vecs[13] = '{1'b0, 3'b010, 32'd1,          32'd1,          32'd2,          1'b0, 1'b0, 1'b0, 1'b0};

    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    req0_a = '0; req0_b = '0; req0_op = '0;
    req1_a = '0; req1_b = '0; req1_op = '0;
    #1;
    check1("rst_rsp_valid", rsp_valid, 1'b0);
    check1("rst_busy", busy, 1'b0);
    check("rst_rsp_data", rsp_data, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 14; i++) run_op(i, vecs[i]);

    // Reset in the middle of RESP; last completed id was 0 so prio is 1 here.
    req1_a = 32'd9; req1_b = 32'd9; req1_op = 3'b010; req1_valid = 1'b1;
    #1;
    check1("mid_accept1", req1_ready, 1'b1);
    tick();
    req1_valid = 1'b0;
    tick();
    check1("mid_in_resp", rsp_valid, 1'b1);
    req0_a = 32'd100; req0_b = 32'd23; req0_op = 3'b010;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check1("mid_rst_rsp_valid", rsp_valid, 1'b0);
    check1("mid_rst_busy", busy, 1'b0);
    check("mid_rst_data", rsp_data, 32'd0);
    check1("mid_rst_id", rsp_id, 1'b0);
    check1("mid_rst_z", rsp_z, 1'b0);
    check1("mid_rst_v", rsp_v, 1'b0);
    check1("mid_rst_s", rsp_s, 1'b0);
    check1("mid_rst_err", rsp_err, 1'b0);
    check1("mid_rst_ready0", req0_ready, 1'b0);
    check1("mid_rst_ready1", req1_ready, 1'b0);
    #2;
    rst_n = 1'b1;
    #1;
    check1("post_rst_ready0", req0_ready, 1'b1);
    check1("post_rst_ready1", req1_ready, 1'b0);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    check1("post_rst_rsp_valid", rsp_valid, 1'b1);
    check1("post_rst_rsp_id", rsp_id, 1'b0);
    check("post_rst_data", rsp_data, 32'd123);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Backpressure: response held 10 cycles while requester 1 waits.
    req0_a = 32'd10; req0_b = 32'd20; req0_op = 3'b010; req0_valid = 1'b1;
    #1;
    check1("bp_accept0", req0_ready, 1'b1);
    tick();
    req0_valid = 1'b0;
    req1_a = 32'd3; req1_b = 32'd4; req1_op = 3'b010; req1_valid = 1'b1;
    tick();
    check1("bp_rsp_valid", rsp_valid, 1'b1);
    check("bp_data", rsp_data, 32'd30);
    held_data = rsp_data;
    bp_bad = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (rsp_valid !== 1'b1 || rsp_data !== held_data || rsp_id !== 1'b0 || busy !== 1'b1 ||
          req0_ready !== 1'b0 || req1_ready !== 1'b0) bp_bad++;
    end
    check("bp_hold_violations", bp_bad, 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check1("bp_release_valid", rsp_valid, 1'b0);
    check1("bp_release_busy", busy, 1'b0);
    check1("bp_waiting_ready1", req1_ready, 1'b1);
    tick();
    req1_valid = 1'b0;
    tick();
    check1("bp_second_id", rsp_id, 1'b1);
    check("bp_second_data", rsp_data, 32'd7);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Both requesters always valid: round-robin instance alternates, fixed instance stays on 0.
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    req0_a = 32'd1; req0_b = 32'd1; req0_op = 3'b010;
    req1_a = 32'd2; req1_b = 32'd2; req1_op = 3'b010;
    req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
    n_rr = 0; n_fp = 0;
    for (int i = 0; i < 4; i++) begin
      rr_id[i] = 1'bx; fp_id[i] = 1'bx; rr_dat[i] = 'x; fp_dat[i] = 'x; rr_cyc[i] = 0;
    end
    for (int c = 0; c < 30; c++) begin
      tick();
      if (rsp_valid && n_rr < 4) begin
        rr_id[n_rr] = rsp_id; rr_dat[n_rr] = rsp_data; rr_cyc[n_rr] = c; n_rr++;
      end
      if (fp_rsp_valid && n_fp < 4) begin
        fp_id[n_fp] = fp_rsp_id; fp_dat[n_fp] = fp_rsp_data; n_fp++;
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    check("rr_count", n_rr, 4);
    check("fp_count", n_fp, 4);
    for (int i = 0; i < 4; i++) begin
      check1($sformatf("rr_id%0d", i), rr_id[i], i[0]);
      check($sformatf("rr_data%0d", i), rr_dat[i], i[0] ? 32'd4 : 32'd2);
      check1($sformatf("fp_id%0d", i), fp_id[i], 1'b0);
      check($sformatf("fp_data%0d", i), fp_dat[i], 32'd2);
      if (i > 0) check($sformatf("rr_spacing%0d", i), rr_cyc[i] - rr_cyc[i-1], 3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one `alu32` instance between two requesters (e.g. the execute stage and an address-generation unit) through valid/ready handshakes. It grants one request at a time under round-robin or fixed priority, registers the operands, and captures the ALU result and flags. It returns them on a single tagged response channel. Overflow is computed locally, and illegal opcodes are reported instead of passing X data.

## Interface
- `FIXED_PRIO`, 0 — 0: round-robin between requesters; 1: requester 0 always wins a simultaneous request.
- `clk` in 1 — rising-edge clock.
- `rst_n` in 1 — asynchronous active-low reset.
- `req0_valid` in 1 — requester 0 has an operation pending.
- `req0_ready` out 1 — requester 0 accepted this cycle when `req0_valid & req0_ready`.
- `req0_a`, `req0_b` in 32 — operands, requester 0.
- `req0_op` in 3 — ALU control code, requester 0.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_op` — same signals for requester 1.
- `rsp_valid` out 1 — response held on the bus.
- `rsp_ready` in 1 — consumer takes the response.
- `rsp_id` out 1 — requester that owns the response.
- `rsp_data` out 32 — ALU result.
- `rsp_z`, `rsp_v`, `rsp_s` out 1 each — zero, signed overflow, sign.
- `rsp_err` out 1 — opcode was illegal.
- `busy` out 1 — high whenever state is not IDLE.

## Operation
- **FSM states:** IDLE, EXEC, RESP.
- **IDLE**
  - Compute `grant` combinationally from the valids and the priority pointer `prio` (1 bit).
  - Only one valid: that requester wins.
  - Both valid: the `prio` requester wins, or requester 0 when `FIXED_PRIO=1`.
  - `reqN_ready = (state==IDLE) & grant==N & reqN_valid`. It is never high for both requesters.
  - On acceptance, latch a, b, op and id into the operand register, then go to EXEC.
- **EXEC**
  - The operand register drives `alu32` a/b/alu_control.
  - At the end of the cycle, capture `alu_out`, `zout` and `sout` into the response register, then go to RESP.
- **Legal ops:** 000 AND, 001 OR, 010 ADD, 011 XOR, 100 NOR, 110 SUB, 111 SLT.
- **Illegal op 101:** capture `rsp_err=1`, `rsp_data=0`, `rsp_z=1`, `rsp_s=0`, `rsp_v=0`.
- **Overflow (`rsp_v`), computed locally; the ALU's vout port is left unconnected:**
  - ADD: `a[31]==b[31] && res[31]!=a[31]`.
  - SUB: `a[31]!=b[31] && res[31]!=a[31]`.
  - All other ops: 0.
- **RESP**
  - Hold `rsp_valid=1` and all rsp fields stable until `rsp_ready`.
  - On `rsp_valid & rsp_ready`: set `prio` to the id not just served, clear `rsp_valid`, go to IDLE.
  - `prio` only updates on response completion.
- Arithmetic is 32-bit modulo. SLT result is 0 or 1, based on the sign of a-b (signed, wrap ignored).
- The requester's operand values after acceptance do not affect the transaction in flight.

## Timing
- **Reset (async, immediate):**
  - State IDLE, `prio=0`.
  - `rsp_valid`, `rsp_id`, `rsp_data`, `rsp_z`, `rsp_v`, `rsp_s`, `rsp_err`, `busy` all 0.
  - Both `reqN_ready` are 0 while `rst_n=0`.
- **Latency:** accept at edge N; EXEC in cycle N+1; `rsp_valid` high from cycle N+2. Minimum 3 cycles per transaction; throughput is one op per 3 cycles when `rsp_ready` is held high.
- `reqN_ready` is never asserted in EXEC or RESP. Requests arriving then wait, and must hold valid and operands stable.
- **Backpressure:** with `rsp_ready` low, RESP holds indefinitely and nothing new is accepted.
- `rsp_ready` asserted with `rsp_valid` low has no effect.
- **Reset mid-operation:** the in-flight transaction is discarded, no response is produced, and `prio` returns to 0.

## Test plan
- **Reset values:** assert `rst_n=0` mid-RESP → `rsp_valid` falls without waiting for a clock edge; all outputs 0; after release, `req0_valid` alone is accepted first.
- **Single ADD from requester 1:** a=5, b=7, op=010 → `req1_ready` high one cycle; two cycles later `rsp_valid=1`, `rsp_id=1`, data=12, z=0, v=0, s=0.
- **Overflow and zero flags:**
  - ADD 0x7FFFFFFF + 1 → data 0x80000000, v=1, s=1.
  - SUB 5 - 5 → data 0, z=1, v=0.
  - SLT a=-3, b=2 → data 1.
- **Round-robin:** both valid continuously, `rsp_ready=1`, `FIXED_PRIO=0` → ids served 0,1,0,1; each transaction 3 cycles. With `FIXED_PRIO=1` → ids 0,0,0…
- **Backpressure:** hold `rsp_ready=0` for 10 cycles → rsp fields stable, `busy=1`, no `req_ready` pulses; releasing `rsp_ready` completes the response in one cycle.
- **Illegal op 101** from requester 0 → `rsp_err=1`, data=0, z=1, v=0; the next legal op responds with `rsp_err=0`.
